// File: rtl/ds1302_sched_ctrl.sv
`default_nettype none
// ds1302_sched_ctrl -- DS1302 command sequencer: init, periodic time poll, user time set. Rev 1.0
// Optional macro DS1302_TCS_EN adds a trickle-charge register write to the init sequence.

module ds1302_sched_ctrl #(
  parameter int unsigned POLL_CYCLES = 32'd50_000_000,
  parameter logic [7:0]  TCS_VALUE   = 8'hA5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Set_Req,
  input  logic [7:0] Set_Sec,
  input  logic [7:0] Set_Min,
  input  logic [7:0] Set_Hour,
  output logic       Set_Ack,
  output logic [1:0] Start_Sig,
  output logic [7:0] Words_Addr,
  output logic [7:0] Write_Data,
  input  logic [7:0] Read_Data,
  input  logic       Done_Sig,
  output logic [7:0] Sec,
  output logic [7:0] Min,
  output logic [7:0] Hour,
  output logic       Time_Valid,
  output logic       Init_Done,
  output logic       Busy
);

  localparam logic [25:0] TMR_LAST = 26'(POLL_CYCLES - 1);
  localparam logic [1:0]  ST_IDLE  = 2'b00;
  localparam logic [1:0]  ST_RD    = 2'b01;
  localparam logic [1:0]  ST_WR    = 2'b10;

  typedef enum logic [3:0] {
    S_INIT_WP    = 4'd0,
    S_INIT_TCS   = 4'd1,
    S_INIT_RDSEC = 4'd2,
    S_INIT_CH    = 4'd3,
    S_IDLE       = 4'd4,
    S_WR_SEC     = 4'd5,
    S_WR_MIN     = 4'd6,
    S_WR_HOUR    = 4'd7,
    S_RD_SEC     = 4'd8,
    S_RD_MIN     = 4'd9,
    S_RD_HOUR    = 4'd10,
    S_UPDATE     = 4'd11
  } state_e;

  state_e      state_q;
  logic        wait_q;
  logic [25:0] timer_q;
  logic        set_pend_q;
  logic        poll_pend_q;
  logic [7:0]  set_sec_q, set_min_q, set_hour_q;
  logic [7:0]  wr_sec_q, wr_min_q, wr_hour_q;
  logic [7:0]  rd_sec_q, rd_min_q, rd_hour_q;

  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_rd;

  // Command byte, data and direction of the transaction owned by each state.
  always_comb begin
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    cmd_rd    = 1'b0;
    case (state_q)
      S_INIT_WP:    begin cmd_addr = 8'h8E; cmd_wdata = 8'h00;      end
      S_INIT_TCS:   begin cmd_addr = 8'h90; cmd_wdata = TCS_VALUE;  end
      S_INIT_RDSEC: begin cmd_addr = 8'h81; cmd_rd    = 1'b1;       end
      S_INIT_CH:    begin cmd_addr = 8'h80; cmd_wdata = rd_sec_q;   end
      S_WR_SEC:     begin cmd_addr = 8'h80; cmd_wdata = wr_sec_q;   end
      S_WR_MIN:     begin cmd_addr = 8'h82; cmd_wdata = wr_min_q;   end
      S_WR_HOUR:    begin cmd_addr = 8'h84; cmd_wdata = wr_hour_q;  end
      S_RD_SEC:     begin cmd_addr = 8'h81; cmd_rd    = 1'b1;       end
      S_RD_MIN:     begin cmd_addr = 8'h83; cmd_rd    = 1'b1;       end
      S_RD_HOUR:    begin cmd_addr = 8'h85; cmd_rd    = 1'b1;       end
      default:      begin cmd_addr = 8'h00;                          end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_INIT_WP;
      wait_q      <= 1'b0;
      timer_q     <= 26'd0;
      set_pend_q  <= 1'b0;
      poll_pend_q <= 1'b0;
      set_sec_q   <= 8'h00;
      set_min_q   <= 8'h00;
      set_hour_q  <= 8'h00;
      wr_sec_q    <= 8'h00;
      wr_min_q    <= 8'h00;
      wr_hour_q   <= 8'h00;
      rd_sec_q    <= 8'h00;
      rd_min_q    <= 8'h00;
      rd_hour_q   <= 8'h00;
      Start_Sig   <= ST_IDLE;
      Words_Addr  <= 8'h00;
      Write_Data  <= 8'h00;
      Sec         <= 8'h00;
      Min         <= 8'h00;
      Hour        <= 8'h00;
      Set_Ack     <= 1'b0;
      Time_Valid  <= 1'b0;
      Init_Done   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Set_Ack    <= 1'b0;
      Time_Valid <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (set_pend_q) begin
            // Freeze the group's values so a later Set_Req only affects the next pass.
            set_pend_q <= 1'b0;
            wr_sec_q   <= set_sec_q & 8'h7F;
            wr_min_q   <= set_min_q;
            wr_hour_q  <= set_hour_q;
            state_q    <= S_WR_SEC;
          end else if (poll_pend_q) begin
            poll_pend_q <= 1'b0;
            state_q     <= S_RD_SEC;
          end
        end

        S_UPDATE: begin
          Sec        <= rd_sec_q;
          Min        <= rd_min_q;
          Hour       <= rd_hour_q;
          Time_Valid <= 1'b1;
          state_q    <= S_IDLE;
        end

        default: begin
          if (!wait_q) begin
            Start_Sig  <= cmd_rd ? ST_RD : ST_WR;
            Words_Addr <= cmd_addr;
            Write_Data <= cmd_wdata;
            Busy       <= 1'b1;
            wait_q     <= 1'b1;
          end else if (Done_Sig) begin
            Start_Sig <= ST_IDLE;
            Busy      <= 1'b0;
            wait_q    <= 1'b0;
            case (state_q)
              S_INIT_WP: begin
`ifdef DS1302_TCS_EN
                state_q <= S_INIT_TCS;
`else
                state_q <= S_INIT_RDSEC;
`endif
              end
              S_INIT_TCS: state_q <= S_INIT_RDSEC;
              S_INIT_RDSEC: begin
                rd_sec_q <= Read_Data & 8'h7F;
                // Only restart the oscillator if the chip reports it halted.
                if (Read_Data[7]) begin
                  state_q <= S_INIT_CH;
                end else begin
                  Init_Done   <= 1'b1;
                  poll_pend_q <= 1'b1;
                  state_q     <= S_IDLE;
                end
              end
              S_INIT_CH: begin
                Init_Done   <= 1'b1;
                poll_pend_q <= 1'b1;
                state_q     <= S_IDLE;
              end
              S_WR_SEC: state_q <= S_WR_MIN;
              S_WR_MIN: state_q <= S_WR_HOUR;
              S_WR_HOUR: begin
                Set_Ack     <= 1'b1;
                poll_pend_q <= 1'b1;
                state_q     <= S_IDLE;
              end
              S_RD_SEC: begin
                rd_sec_q <= Read_Data & 8'h7F;
                state_q  <= S_RD_MIN;
              end
              S_RD_MIN: begin
                rd_min_q <= Read_Data & 8'h7F;
                state_q  <= S_RD_HOUR;
              end
              S_RD_HOUR: begin
                rd_hour_q <= Read_Data & 8'h3F;
                state_q   <= S_UPDATE;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase

      // Placed after the FSM so a request arriving on a group-start cycle stays pending.
      if (Set_Req) begin
        set_sec_q  <= Set_Sec;
        set_min_q  <= Set_Min;
        set_hour_q <= Set_Hour;
        set_pend_q <= 1'b1;
      end

      if (Init_Done) begin
        if (timer_q == TMR_LAST) begin
          timer_q     <= 26'd0;
          poll_pend_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 26'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ds1302_sched_ctrl.sv
`default_nettype none
// tb_ds1302_sched_ctrl -- scoreboard bench with a behavioural DS1302 engine/chip model. Rev 1.0

module tb_ds1302_sched_ctrl;

  localparam int POLL = 3000;

  logic       CLK;
  logic       RSTn;
  logic       Set_Req;
  logic [7:0] Set_Sec, Set_Min, Set_Hour;
  logic       Set_Ack;
  logic [1:0] Start_Sig;
  logic [7:0] Words_Addr, Write_Data, Read_Data;
  logic       Done_Sig;
  logic [7:0] Sec, Min, Hour;
  logic       Time_Valid, Init_Done, Busy;

  ds1302_sched_ctrl #(.POLL_CYCLES(POLL), .TCS_VALUE(8'hA5)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Set_Req(Set_Req), .Set_Sec(Set_Sec), .Set_Min(Set_Min), .Set_Hour(Set_Hour),
    .Set_Ack(Set_Ack),
    .Start_Sig(Start_Sig), .Words_Addr(Words_Addr), .Write_Data(Write_Data),
    .Read_Data(Read_Data), .Done_Sig(Done_Sig),
    .Sec(Sec), .Min(Min), .Hour(Hour),
    .Time_Valid(Time_Valid), .Init_Done(Init_Done), .Busy(Busy)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t        exp_txn[$];
  logic [23:0] exp_tv[$];
  int          tv_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          tv_cnt = 0;
  int          ack_cnt = 0;
  int          hold_bad = 0;
  logic [7:0]  chip_sec, chip_min, chip_hour;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_txn.push_back('{st: 2'b10, addr: a, data: d});
  endtask

  task automatic push_r(input logic [7:0] a);
    exp_txn.push_back('{st: 2'b01, addr: a, data: 8'h00});
  endtask

  task automatic push_poll(input logic [23:0] t);
    push_r(8'h81);
    push_r(8'h83);
    push_r(8'h85);
    exp_tv.push_back(t);
  endtask

  task automatic set_req(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    Set_Req  = 1'b1;
    Set_Sec  = s;
    Set_Min  = m;
    Set_Hour = h;
    @(negedge CLK);
    Set_Req  = 1'b0;
  endtask

  task automatic wait_txn(input string tag, input logic [1:0] st, input logic [7:0] a, input int budget);
    int n = 0;
    while (!(Start_Sig == st && Words_Addr == a) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_tv(input string tag, input int cnt, input int budget);
    int n = 0;
    while (tv_cnt < cnt && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) chk(tag, tv_cnt, cnt);
  endtask

  // Engine + chip model: Done 40 cycles after Start, reads return chip registers.
  initial begin : engine
    txn_t e;
    Done_Sig  = 1'b0;
    Read_Data = 8'h00;
    chip_sec  = 8'hC5;
    chip_min  = 8'hD9;
    chip_hour = 8'hE3;
    forever begin
      @(negedge CLK);
      if (RSTn && Start_Sig != 2'b00) begin
        e = '0;
        if (exp_txn.size() != 0) e = exp_txn.pop_front();
        else chk("txn_extra", {Start_Sig, Words_Addr}, 32'd0);
        chk("txn_cmd", {Start_Sig, Words_Addr, (Start_Sig == 2'b10) ? Write_Data : 8'h00, Busy},
            {e.st, e.addr, e.data, 1'b1});
        repeat (39) @(negedge CLK);
        chk("txn_hold", {Start_Sig, Words_Addr, (Start_Sig == 2'b10) ? Write_Data : 8'h00},
            {e.st, e.addr, e.data});
        if (Start_Sig == 2'b01) begin
          case (Words_Addr)
            8'h81:   Read_Data = chip_sec;
            8'h83:   Read_Data = chip_min;
            8'h85:   Read_Data = chip_hour;
            default: Read_Data = 8'h00;
          endcase
        end else begin
          case (Words_Addr)
            8'h80:   chip_sec  = Write_Data;
            8'h82:   chip_min  = Write_Data;
            8'h84:   chip_hour = Write_Data;
            default: ;
          endcase
        end
        Done_Sig = 1'b1;
        @(negedge CLK);
        Done_Sig = 1'b0;
        chk("start_drop", {Start_Sig, Busy}, 32'd0);
      end
    end
  end

  initial begin : monitor
    logic [23:0] snap_prev;
    logic [23:0] cur;
    logic [23:0] t;
    snap_prev = 24'h0;
    forever begin
      @(negedge CLK);
      cur = {Sec, Min, Hour};
      if (Time_Valid) begin
        tv_cnt++;
        tv_cyc.push_back(cyc);
        if (exp_tv.size() != 0) begin
          t = exp_tv.pop_front();
          chk("tv_time", cur, t);
        end else begin
          chk("tv_extra", cur, 32'd0);
        end
        if (tv_cnt == 1) chk("init_done", Init_Done, 1'b1);
      end else if (cur != snap_prev) begin
        hold_bad++;
      end
      snap_prev = cur;
      if (Set_Ack) ack_cnt++;
    end
  end

  initial begin : main
    RSTn     = 1'b0;
    Set_Req  = 1'b0;
    Set_Sec  = 8'h00;
    Set_Min  = 8'h00;
    Set_Hour = 8'h00;

    // Init: clear WP, read seconds (halted, 0xC5), restart oscillator keeping 45 s, then one poll.
    push_w(8'h8E, 8'h00);
`ifdef DS1302_TCS_EN
    push_w(8'h90, 8'hA5);
`endif
    push_r(8'h81);
    push_w(8'h80, 8'h45);
    push_poll(24'h455923);

    repeat (3) @(negedge CLK);
    chk("rst_start", {Start_Sig, Busy}, 32'd0);
    chk("rst_cmd", {Words_Addr, Write_Data}, 32'd0);
    chk("rst_time", {Sec, Min, Hour}, 32'd0);
    chk("rst_flags", {Set_Ack, Time_Valid, Init_Done}, 32'd0);

    RSTn = 1'b1;
    repeat (5) @(negedge CLK);
    chk("init_done_early", Init_Done, 1'b0);
    wait_tv("tv1_timeout", 1, 2000);

    // Set A while idle; CH bit forced to 0, poll follows.
    @(negedge CLK);
    push_w(8'h80, 8'h45);
    push_w(8'h82, 8'h10);
    push_w(8'h84, 8'h07);
    push_poll(24'h451007);
    set_req(8'hC5, 8'h10, 8'h07);

    // Set B during RD_MIN of the follow-up poll.
    wait_txn("rdmin_timeout", 2'b01, 8'h83, 2000);
    push_w(8'h80, 8'h30);
    push_w(8'h82, 8'h20);
    push_w(8'h84, 8'h12);
    set_req(8'h30, 8'h20, 8'h12);

    // Set C during WR_MIN of set B; B keeps its own values.
    wait_txn("wrmin_timeout", 2'b10, 8'h82, 2000);
    push_w(8'h80, 8'h11);
    push_w(8'h82, 8'h22);
    push_w(8'h84, 8'h13);
    push_poll(24'h112213);
    set_req(8'h11, 8'h22, 8'h13);

    wait_tv("tv3_timeout", 3, 3000);
    chk("ack_count", ack_cnt, 3);

    // Two timer-driven polls.
    push_poll(24'h112213);
    push_poll(24'h112213);
    wait_tv("tv5_timeout", 5, 8000);
    repeat (5) @(negedge CLK);

    chk("tv_count", tv_cyc.size(), 5);
    if (tv_cyc.size() >= 5) chk("poll_period", tv_cyc[4] - tv_cyc[3], POLL);
    chk("txn_left", exp_txn.size(), 0);
    chk("tv_left", exp_tv.size(), 0);
    chk("time_hold", hold_bad, 0);
    chk("ack_final", ack_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
